// File: rtl/id_stage.sv
// ---------------------------------------------------------------------------
// id_stage
//   Decode stage that sits between fetch and EX. It accepts one 32-bit
//   instruction per handshake, decodes it into {alu_ctrl, use_imm, imm},
//   reads the two source operands from a 32 x 32 register file and parks the
//   result in a single ID/EX pipeline register. A per-register busy
//   scoreboard holds back any instruction that would read or overwrite a
//   register that an older, still in-flight op is going to write. The
//   writeback port updates the register file and retires busy bits.
//
// Ports
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready instruction handshake from fetch, in_instr = word
//   flush             drop whatever sits in the ID/EX register
//   wb_en/wb_rd/wb_data  writeback write port (x0 writes are ignored)
//   out_valid/out_ready  handshake towards EX
//   out_rs1_val, out_rs2_val, out_use_imm, out_alu_ctrl, out_imm
//                     operands and control for EX
//   out_rd, out_wb_en destination register and whether it is written
//   illegal_instr     one-cycle pulse after an undecodable word is consumed
// ---------------------------------------------------------------------------
module id_stage #(
  parameter int NREGS = 32,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [XLEN-1:0] in_instr,
  output logic            in_ready,
  input  logic            flush,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_rs1_val,
  output logic [XLEN-1:0] out_rs2_val,
  output logic            out_use_imm,
  output logic [3:0]      out_alu_ctrl,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_rd,
  output logic            out_wb_en,
  output logic            illegal_instr
);

  localparam logic [6:0] OPC_R     = 7'b0110011;
  localparam logic [6:0] OPC_I     = 7'b0010011;
  localparam logic [6:0] OPC_CUST0 = 7'b0001011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [3:0] ALU_ADD    = 4'h0;
  localparam logic [3:0] ALU_SUB    = 4'h1;
  localparam logic [3:0] ALU_AND    = 4'h2;
  localparam logic [3:0] ALU_OR     = 4'h3;
  localparam logic [3:0] ALU_XOR    = 4'h4;
  localparam logic [3:0] ALU_RELU   = 4'h8;
  localparam logic [3:0] ALU_MATMUL = 4'h9;
  localparam logic [3:0] ALU_VECADD = 4'hA;
  localparam logic [3:0] ALU_MPOOL  = 4'hB;

  // Instruction fields
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic [4:0] rd;

  assign opcode = in_instr[6:0];
  assign rd     = in_instr[11:7];
  assign funct3 = in_instr[14:12];
  assign rs1    = in_instr[19:15];
  assign rs2    = in_instr[24:20];
  assign funct7 = in_instr[31:25];

  // Decoder outputs
  logic            dec_legal;
  logic [3:0]      dec_alu_ctrl;
  logic            dec_use_imm;
  logic [XLEN-1:0] dec_imm;
  logic            dec_uses_rs2;

  // Architectural state
  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;
  logic [NREGS-1:0] wb_clr_mask;
  logic [NREGS-1:0] busy_eff;

  logic            wb_write;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic            stall;
  logic            accept;
  logic            issue;

  // Decode the presented word. Defaults describe an illegal word; each legal
  // encoding raises dec_legal. rs2 only matters for hazards on ops that
  // really read it: RELU and MPOOL are single-source, I-type has no rs2.
  always_comb begin
    dec_legal    = 1'b0;
    dec_alu_ctrl = ALU_ADD;
    dec_use_imm  = 1'b0;
    dec_imm      = '0;
    dec_uses_rs2 = 1'b0;
    case (opcode)
      OPC_R: begin
        dec_uses_rs2 = 1'b1;
        case (funct3)
          3'b000: begin
            if (funct7 == F7_BASE) begin
              dec_legal    = 1'b1;
              dec_alu_ctrl = ALU_ADD;
            end else if (funct7 == F7_ALT) begin
              dec_legal    = 1'b1;
              dec_alu_ctrl = ALU_SUB;
            end
          end
          3'b111: begin
            dec_legal    = (funct7 == F7_BASE);
            dec_alu_ctrl = ALU_AND;
          end
          3'b110: begin
            dec_legal    = (funct7 == F7_BASE);
            dec_alu_ctrl = ALU_OR;
          end
          3'b100: begin
            dec_legal    = (funct7 == F7_BASE);
            dec_alu_ctrl = ALU_XOR;
          end
          default: ;
        endcase
      end
      OPC_I: begin
        dec_use_imm = 1'b1;
        dec_imm     = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
        case (funct3)
          3'b000: begin
            dec_legal    = 1'b1;
            dec_alu_ctrl = ALU_ADD;
          end
          3'b111: begin
            dec_legal    = 1'b1;
            dec_alu_ctrl = ALU_AND;
          end
          3'b110: begin
            dec_legal    = 1'b1;
            dec_alu_ctrl = ALU_OR;
          end
          3'b100: begin
            dec_legal    = 1'b1;
            dec_alu_ctrl = ALU_XOR;
          end
          default: ;
        endcase
      end
      OPC_CUST0: begin
        if (funct7 == F7_BASE) begin
          case (funct3)
            3'b000: begin
              dec_legal    = 1'b1;
              dec_alu_ctrl = ALU_RELU;
            end
            3'b001: begin
              dec_legal    = 1'b1;
              dec_alu_ctrl = ALU_MATMUL;
              dec_uses_rs2 = 1'b1;
            end
            3'b010: begin
              dec_legal    = 1'b1;
              dec_alu_ctrl = ALU_VECADD;
              dec_uses_rs2 = 1'b1;
            end
            3'b011: begin
              dec_legal    = 1'b1;
              dec_alu_ctrl = ALU_MPOOL;
            end
            default: ;
          endcase
        end
      end
      default: ;
    endcase
  end

  // A writeback to x0 is a no-op everywhere: no regfile write, no busy clear.
  assign wb_write = wb_en && (wb_rd != 5'd0);

  // Register reads bypass the writeback port so an op decoded in the same
  // cycle as its producer's writeback sees the fresh value.
  assign rs1_val = (rs1 == 5'd0) ? '0 :
                   ((wb_write && (wb_rd == rs1)) ? wb_data : regs[rs1]);
  assign rs2_val = (rs2 == 5'd0) ? '0 :
                   ((wb_write && (wb_rd == rs2)) ? wb_data : regs[rs2]);

  // One-hot mask of the busy bit retired by this cycle's writeback.
  always_comb begin
    wb_clr_mask = '0;
    if (wb_write) begin
      wb_clr_mask[wb_rd] = 1'b1;
    end
  end

  // Hazard view of the scoreboard already excludes the bit being retired
  // right now, so a consumer can issue in the same cycle as the writeback.
  // busy[0] is never set, which keeps x0 permanently hazard-free.
  assign busy_eff = busy & ~wb_clr_mask;

  assign stall = in_valid &&
                 (busy_eff[rs1] ||
                  (dec_legal && dec_uses_rs2 && busy_eff[rs2]) ||
                  busy_eff[rd]);

  assign in_ready = !rst && !stall && (!out_valid || out_ready) && !flush;
  assign accept   = in_valid && in_ready;
  assign issue    = accept && dec_legal;

  // Next scoreboard: retire the writeback, drop the flushed op's claim, then
  // apply the new claim last so that a same-cycle set beats a clear.
  always_comb begin
    busy_nxt = busy_eff;
    if (flush && out_valid && out_wb_en) begin
      busy_nxt[out_rd] = 1'b0;
    end
    if (issue && (rd != 5'd0)) begin
      busy_nxt[rd] = 1'b1;
    end
  end

  // Scoreboard register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  // Register file: cleared by reset, written only by the writeback port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_write) begin
      regs[wb_rd] <= wb_data;
    end
  end

  // ID/EX register. A legal accepted op reloads every field. Flush and a
  // downstream consume only drop out_valid; the payload keeps its last
  // value. While EX back-pressures nothing here changes because in_ready
  // is low and no branch fires.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_rs1_val  <= '0;
      out_rs2_val  <= '0;
      out_use_imm  <= 1'b0;
      out_alu_ctrl <= '0;
      out_imm      <= '0;
      out_rd       <= '0;
      out_wb_en    <= 1'b0;
    end else if (issue) begin
      out_valid    <= 1'b1;
      out_rs1_val  <= rs1_val;
      out_rs2_val  <= rs2_val;
      out_use_imm  <= dec_use_imm;
      out_alu_ctrl <= dec_alu_ctrl;
      out_imm      <= dec_imm;
      out_rd       <= rd;
      out_wb_en    <= (rd != 5'd0);
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Illegal words are swallowed by the handshake and flagged for one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal_instr <= 1'b0;
    end else begin
      illegal_instr <= accept && !dec_legal;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// ---------------------------------------------------------------------------
// tb_id_stage
//   Self-checking bench for id_stage. A behavioural model (register array,
//   busy flags, one pending-op record) predicts in_ready every cycle and the
//   registered outputs after every clock edge. Directed sequences with
//   literal expectations come first, then a long randomized run.
// ---------------------------------------------------------------------------
module tb_id_stage;

  localparam logic [6:0] OPC_R   = 7'b0110011;
  localparam logic [6:0] OPC_I   = 7'b0010011;
  localparam logic [6:0] OPC_CU  = 7'b0001011;
  localparam logic [6:0] OPC_LUI = 7'b0110111;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_instr;
  logic        in_ready;
  logic        flush;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_rs1_val;
  logic [31:0] out_rs2_val;
  logic        out_use_imm;
  logic [3:0]  out_alu_ctrl;
  logic [31:0] out_imm;
  logic [4:0]  out_rd;
  logic        out_wb_en;
  logic        illegal_instr;

  id_stage dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_instr      (in_instr),
    .in_ready      (in_ready),
    .flush         (flush),
    .wb_en         (wb_en),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_rs1_val   (out_rs1_val),
    .out_rs2_val   (out_rs2_val),
    .out_use_imm   (out_use_imm),
    .out_alu_ctrl  (out_alu_ctrl),
    .out_imm       (out_imm),
    .out_rd        (out_rd),
    .out_wb_en     (out_wb_en),
    .illegal_instr (illegal_instr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state
  logic [31:0] m_regs [32];
  bit          m_busy [32];
  bit          m_valid;
  logic [31:0] m_rs1v;
  logic [31:0] m_rs2v;
  bit          m_use_imm;
  logic [3:0]  m_ctrl;
  logic [31:0] m_imm;
  logic [4:0]  m_rd;
  bit          m_wb_en;
  bit          m_illegal;
  bit          last_accept;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("[TB] FAIL %s: actual %h required %h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
    m_valid   = 1'b0;
    m_rs1v    = '0;
    m_rs2v    = '0;
    m_use_imm = 1'b0;
    m_ctrl    = '0;
    m_imm     = '0;
    m_rd      = '0;
    m_wb_en   = 1'b0;
    m_illegal = 1'b0;
  endfunction

  // Instruction-set table: what each word means, independent of any datapath.
  function automatic void model_decode(input logic [31:0] w, output bit legal,
                                       output logic [3:0] ctrl, output bit use_imm,
                                       output logic [31:0] imm, output bit uses_rs2);
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    op = w[6:0];
    f3 = w[14:12];
    f7 = w[31:25];
    legal = 1'b0; ctrl = 4'd0; use_imm = 1'b0; imm = 32'd0; uses_rs2 = 1'b0;
    if (op == OPC_R) begin
      legal = 1'b1; uses_rs2 = 1'b1;
      if (f3 == 3'd0 && f7 == 7'h00)      ctrl = 4'd0;
      else if (f3 == 3'd0 && f7 == 7'h20) ctrl = 4'd1;
      else if (f3 == 3'd7 && f7 == 7'h00) ctrl = 4'd2;
      else if (f3 == 3'd6 && f7 == 7'h00) ctrl = 4'd3;
      else if (f3 == 3'd4 && f7 == 7'h00) ctrl = 4'd4;
      else begin legal = 1'b0; uses_rs2 = 1'b0; end
    end else if (op == OPC_I) begin
      use_imm = 1'b1;
      imm     = {{20{w[31]}}, w[31:20]};
      legal   = 1'b1;
      if (f3 == 3'd0)      ctrl = 4'd0;
      else if (f3 == 3'd7) ctrl = 4'd2;
      else if (f3 == 3'd6) ctrl = 4'd3;
      else if (f3 == 3'd4) ctrl = 4'd4;
      else legal = 1'b0;
    end else if (op == OPC_CU && f7 == 7'h00 && f3 <= 3'd3) begin
      legal    = 1'b1;
      ctrl     = 4'd8 + {1'b0, f3};
      uses_rs2 = (f3 == 3'd1) || (f3 == 3'd2);
    end
    if (!legal) begin
      use_imm = 1'b0;
      imm     = 32'd0;
    end
  endfunction

  function automatic bit eff_busy(input logic [4:0] r, input bit clr, input logic [4:0] wr);
    return (r != 5'd0) && m_busy[r] && !(clr && wr == r);
  endfunction

  function automatic logic [31:0] read_model(input logic [4:0] r, input bit clr,
                                             input logic [4:0] wr, input logic [31:0] wd);
    if (r == 5'd0) return 32'd0;
    if (clr && wr == r) return wd;
    return m_regs[r];
  endfunction

  function automatic logic [31:0] enc(input logic [6:0] f7, input logic [4:0] r2,
                                      input logic [4:0] r1, input logic [2:0] f3,
                                      input logic [4:0] rd, input logic [6:0] op);
    return {f7, r2, r1, f3, rd, op};
  endfunction

  // Compare every registered output against the model's pending-op record.
  task automatic compareAll();
    checkOutput("out_valid",     32'(out_valid),     32'(m_valid));
    checkOutput("out_rs1_val",   out_rs1_val,        m_rs1v);
    checkOutput("out_rs2_val",   out_rs2_val,        m_rs2v);
    checkOutput("out_use_imm",   32'(out_use_imm),   32'(m_use_imm));
    checkOutput("out_alu_ctrl",  32'(out_alu_ctrl),  32'(m_ctrl));
    checkOutput("out_imm",       out_imm,            m_imm);
    checkOutput("out_rd",        32'(out_rd),        32'(m_rd));
    checkOutput("out_wb_en",     32'(out_wb_en),     32'(m_wb_en));
    checkOutput("illegal_instr", 32'(illegal_instr), 32'(m_illegal));
  endtask

  // Drive one cycle of inputs, predict and check in_ready, advance the model
  // over the clock edge and check the registered outputs.
  task automatic applyStimulus(input bit iv, input logic [31:0] instr, input bit fl,
                               input bit wbe, input logic [4:0] wbr,
                               input logic [31:0] wbd, input bit ordy);
    bit legal, ui, u2, clr, stall, exp_ready, acc;
    logic [3:0]  c;
    logic [31:0] im, v1, v2;
    logic [4:0]  r1, r2, rd;
    @(negedge clk);
    in_valid  = iv;
    in_instr  = instr;
    flush     = fl;
    wb_en     = wbe;
    wb_rd     = wbr;
    wb_data   = wbd;
    out_ready = ordy;
    #1;
    model_decode(instr, legal, c, ui, im, u2);
    r1 = instr[19:15];
    r2 = instr[24:20];
    rd = instr[11:7];
    clr = wbe && (wbr != 5'd0);
    stall = iv && (eff_busy(r1, clr, wbr) || (u2 && eff_busy(r2, clr, wbr)) ||
                   eff_busy(rd, clr, wbr));
    exp_ready = !stall && (!m_valid || ordy) && !fl;
    acc = iv && exp_ready;
    v1 = read_model(r1, clr, wbr, wbd);
    v2 = read_model(r2, clr, wbr, wbd);
    checkOutput("in_ready", 32'(in_ready), 32'(exp_ready));
    @(posedge clk);
    if (acc && legal) begin
      m_valid   = 1'b1;
      m_rs1v    = v1;
      m_rs2v    = v2;
      m_use_imm = ui;
      m_ctrl    = c;
      m_imm     = im;
      m_rd      = rd;
      m_wb_en   = (rd != 5'd0);
    end else if (fl) begin
      if (m_valid && m_wb_en) m_busy[m_rd] = 1'b0;
      m_valid = 1'b0;
    end else if (m_valid && ordy) begin
      m_valid = 1'b0;
    end
    if (clr) begin
      m_regs[wbr] = wbd;
      m_busy[wbr] = 1'b0;
    end
    if (acc && legal && rd != 5'd0) m_busy[rd] = 1'b1;
    m_illegal = acc && !legal;
    #1;
    compareAll();
    last_accept = acc;
  endtask

  // Assert reset asynchronously (between edges), check everything is cleared
  // at once, then release with idle inputs.
  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_clear();
    checkOutput("rst_in_ready",    32'(in_ready),      32'd0);
    checkOutput("rst_out_valid",   32'(out_valid),     32'd0);
    checkOutput("rst_rs1_val",     out_rs1_val,        32'd0);
    checkOutput("rst_rs2_val",     out_rs2_val,        32'd0);
    checkOutput("rst_use_imm",     32'(out_use_imm),   32'd0);
    checkOutput("rst_alu_ctrl",    32'(out_alu_ctrl),  32'd0);
    checkOutput("rst_imm",         out_imm,            32'd0);
    checkOutput("rst_rd",          32'(out_rd),        32'd0);
    checkOutput("rst_wb_en",       32'(out_wb_en),     32'd0);
    checkOutput("rst_illegal",     32'(illegal_instr), 32'd0);
    @(negedge clk);
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_instr  = '0;
    flush     = 1'b0;
    wb_en     = 1'b0;
    wb_rd     = '0;
    wb_data   = '0;
    out_ready = 1'b0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0]  a, b, d;
    logic [11:0] imm12;
    logic [31:0] w;
    int sel;
    a     = 5'($urandom_range(0, 7));
    b     = 5'($urandom_range(0, 7));
    d     = 5'($urandom_range(0, 7));
    imm12 = 12'($urandom());
    sel   = $urandom_range(0, 15);
    case (sel)
      0:       w = enc(7'h00, b, a, 3'd0, d, OPC_R);
      1:       w = enc(7'h20, b, a, 3'd0, d, OPC_R);
      2:       w = enc(7'h00, b, a, 3'd7, d, OPC_R);
      3:       w = enc(7'h00, b, a, 3'd6, d, OPC_R);
      4:       w = enc(7'h00, b, a, 3'd4, d, OPC_R);
      5, 6:    w = {imm12, a, 3'd0, d, OPC_I};
      7:       w = {imm12, a, 3'd7, d, OPC_I};
      8:       w = {imm12, a, 3'd6, d, OPC_I};
      9:       w = {imm12, a, 3'd4, d, OPC_I};
      10:      w = enc(7'h00, b, a, 3'd0, d, OPC_CU);
      11:      w = enc(7'h00, b, a, 3'd1, d, OPC_CU);
      12:      w = enc(7'h00, b, a, 3'd2, d, OPC_CU);
      13:      w = enc(7'h00, b, a, 3'd3, d, OPC_CU);
      14: begin
        w = $urandom();
        w[6:0] = OPC_LUI;
      end
      default: w = 32'hFFFF_FFFF;
    endcase
    return w;
  endfunction

  initial begin
    logic [31:0] pend;
    bit          have_pend;
    bit          wbe, fl, ordy;
    logic [4:0]  wbr;
    int          start;
    logic [31:0] ops  [7];
    logic [3:0]  ctrl [7];

    rst = 1'b1; in_valid = 1'b0; in_instr = '0; flush = 1'b0;
    wb_en = 1'b0; wb_rd = '0; wb_data = '0; out_ready = 1'b0;
    last_accept = 1'b0;
    model_clear();
    doReset();

    // ADDI x1,x0,5 then ADD x2,x1,x1 waiting on x1's writeback
    applyStimulus(1, 32'h0050_0093, 0, 0, 5'd0, 32'd0, 1);
    checkOutput("lit_addi_imm",  out_imm,              32'h5);
    checkOutput("lit_addi_uimm", 32'(out_use_imm),     32'd1);
    checkOutput("lit_addi_rd",   32'(out_rd),          32'd1);
    applyStimulus(1, 32'h0010_8133, 0, 0, 5'd0, 32'd0, 1);
    checkOutput("lit_add_stall1", 32'(last_accept),    32'd0);
    applyStimulus(1, 32'h0010_8133, 0, 0, 5'd0, 32'd0, 1);
    checkOutput("lit_add_stall2", 32'(last_accept),    32'd0);
    applyStimulus(1, 32'h0010_8133, 0, 1, 5'd1, 32'd5, 1);
    checkOutput("lit_add_valid", 32'(out_valid),       32'd1);
    checkOutput("lit_add_rs1",   out_rs1_val,          32'd5);
    checkOutput("lit_add_rs2",   out_rs2_val,          32'd5);
    checkOutput("lit_add_ctrl",  32'(out_alu_ctrl),    32'd0);

    // RELU x4,x3 decoded in the cycle x3 is written back
    applyStimulus(1, 32'h0001_820B, 0, 1, 5'd3, 32'h80, 1);
    checkOutput("lit_relu_rs1",  out_rs1_val,          32'h80);
    checkOutput("lit_relu_ctrl", 32'(out_alu_ctrl),    32'h8);

    // ADDI x5,x0,-1 and ADD x0,x1,x1
    applyStimulus(1, 32'hFFF0_0293, 0, 0, 5'd0, 32'd0, 1);
    checkOutput("lit_neg_imm",   out_imm,              32'hFFFF_FFFF);
    checkOutput("lit_neg_uimm",  32'(out_use_imm),     32'd1);
    applyStimulus(1, 32'h0010_8033, 0, 0, 5'd0, 32'd0, 1);
    checkOutput("lit_x0_wben",   32'(out_wb_en),       32'd0);

    // Remaining encodings, all on x0 so no busy bits build up
    ops[0] = enc(7'h20, 5'd0, 5'd0, 3'd0, 5'd0, OPC_R);  ctrl[0] = 4'h1;
    ops[1] = enc(7'h00, 5'd0, 5'd0, 3'd7, 5'd0, OPC_R);  ctrl[1] = 4'h2;
    ops[2] = enc(7'h00, 5'd0, 5'd0, 3'd6, 5'd0, OPC_R);  ctrl[2] = 4'h3;
    ops[3] = enc(7'h00, 5'd0, 5'd0, 3'd4, 5'd0, OPC_R);  ctrl[3] = 4'h4;
    ops[4] = enc(7'h00, 5'd0, 5'd0, 3'd1, 5'd0, OPC_CU); ctrl[4] = 4'h9;
    ops[5] = enc(7'h00, 5'd0, 5'd0, 3'd2, 5'd0, OPC_CU); ctrl[5] = 4'hA;
    ops[6] = enc(7'h00, 5'd0, 5'd0, 3'd3, 5'd0, OPC_CU); ctrl[6] = 4'hB;
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1, ops[i], 0, 0, 5'd0, 32'd0, 1);
      checkOutput("lit_enc_ctrl", 32'(out_alu_ctrl), 32'(ctrl[i]));
      checkOutput("lit_enc_uimm", 32'(out_use_imm),  32'd0);
    end

    // SUB x6,x1,x1 held by EX for 3 cycles, then flushed; ADD x7,x6,x6 then
    // issues at once because the flush released x6
    applyStimulus(1, 32'h4010_8333, 0, 0, 5'd0, 32'd0, 1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 32'h0063_03B3, 0, 0, 5'd0, 32'd0, 0);
    end
    checkOutput("lit_hold_valid", 32'(out_valid), 32'd1);
    checkOutput("lit_hold_rd",    32'(out_rd),    32'd6);
    applyStimulus(1, 32'h0063_03B3, 1, 0, 5'd0, 32'd0, 0);
    checkOutput("lit_flush_valid", 32'(out_valid), 32'd0);
    applyStimulus(1, 32'h0063_03B3, 0, 0, 5'd0, 32'd0, 1);
    checkOutput("lit_after_flush_valid", 32'(out_valid), 32'd1);
    checkOutput("lit_after_flush_rs1",   out_rs1_val,    32'd0);

    // Illegal word: one pulse, no op
    applyStimulus(1, 32'hFFFF_FFFF, 0, 0, 5'd0, 32'd0, 1);
    checkOutput("lit_illegal_pulse", 32'(illegal_instr), 32'd1);
    checkOutput("lit_illegal_valid", 32'(out_valid),     32'd0);
    applyStimulus(0, 32'd0, 0, 0, 5'd0, 32'd0, 1);
    checkOutput("lit_illegal_clear", 32'(illegal_instr), 32'd0);

    // ADD x8,x2,x0 stalls on x2, reset lands mid-stall
    applyStimulus(1, enc(7'h00, 5'd0, 5'd2, 3'd0, 5'd8, OPC_R), 0, 0, 5'd0, 32'd0, 1);
    checkOutput("lit_pre_rst_stall", 32'(last_accept), 32'd0);
    doReset();

    // Randomized traffic with a fetch that holds its word until accepted
    have_pend = 1'b0;
    pend      = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!have_pend && $urandom_range(0, 99) < 70) begin
        pend      = rand_instr();
        have_pend = 1'b1;
      end
      wbe = ($urandom_range(0, 99) < 35);
      wbr = 5'($urandom_range(0, 7));
      if (wbe && $urandom_range(0, 99) < 85) begin
        start = $urandom_range(0, 7);
        for (int k = 0; k < 8; k++) begin
          if (m_busy[(start + k) % 8]) begin
            wbr = 5'((start + k) % 8);
            break;
          end
        end
      end
      fl   = ($urandom_range(0, 99) < 4);
      ordy = ($urandom_range(0, 99) < 75);
      applyStimulus(have_pend, pend, fl, wbe, wbr, $urandom(), ordy);
      if (last_accept) have_pend = 1'b0;
      if (cyc % 1000 == 700) doReset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
